biriscv_mul_arbiter: RTL and testbench

BIRISCV_MUL_ARBITER -- requirements
Module: biriscv_mul_arbiter

---
 rtl/biriscv_mul_arbiter.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_biriscv_mul_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_mul_arbiter.sv
// -----------------------------------------------------------------------------
// biriscv_mul_arbiter
//
// Shares one iterative multiplier between two requesters. One multiply is in
// flight at a time. The arbiter grants a requester, forwards its operands
// with a start pulse, remembers who owns the operation and where the result
// goes, and routes the returning result to that requester's writeback port.
//
// Arbitration is round-robin. A tie goes to the requester that did not win
// last. The cycle in which a result returns can also issue the next multiply
// (back-to-back). A pipeline flush kills the outstanding multiply, so its
// result is dropped when it returns. A watchdog abandons an operation whose
// result never comes back and raises a sticky error.
//
// Ports
//   clk_i, rst_i             clock; asynchronous active-high reset
//   reqN_valid_i             requester N (N = 0,1) presents a multiply
//   reqN_ready_o             requester N is accepted this cycle (combinational)
//   reqN_ra_i, reqN_rb_i     operands A and B of requester N (32 bits)
//   reqN_rd_i                destination register index of requester N
//   mul_valid_o              start pulse to the multiplier (combinational)
//   mul_ra_o, mul_rb_o       operands to the multiplier; 0 when no start
//   mul_wb_valid_i           multiplier result valid
//   mul_wb_value_i           multiplier result value
//   flush_i                  pipeline flush; kills any outstanding multiply
//   wbN_valid_o              one-cycle writeback strobe to requester N
//   wbN_rd_o, wbN_value_o    writeback register index / value; held when idle
//   err_o                    sticky watchdog error, cleared only by reset
//
// Parameter
//   WDOG_LIMIT               number of busy cycles without a result before the
//                            operation is abandoned. The counter is 4 bits
//                            wide, so useful values are 1..15.
// -----------------------------------------------------------------------------
module biriscv_mul_arbiter #(
  parameter int WDOG_LIMIT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_ra_i,
  input  logic [31:0] req0_rb_i,
  input  logic [4:0]  req0_rd_i,

  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_ra_i,
  input  logic [31:0] req1_rb_i,
  input  logic [4:0]  req1_rd_i,

  output logic        mul_valid_o,
  output logic [31:0] mul_ra_o,
  output logic [31:0] mul_rb_o,

  input  logic        mul_wb_valid_i,
  input  logic [31:0] mul_wb_value_i,

  input  logic        flush_i,

  output logic        wb0_valid_o,
  output logic [4:0]  wb0_rd_o,
  output logic [31:0] wb0_value_o,

  output logic        wb1_valid_o,
  output logic [4:0]  wb1_rd_o,
  output logic [31:0] wb1_value_o,

  output logic        err_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [3:0] WDOG_LIMIT_C = 4'(WDOG_LIMIT);

  // Control state
  state_t      state_q, state_d;
  logic        owner_q, owner_d;        // requester that owns the in-flight op
  logic [4:0]  rd_q, rd_d;              // destination of the in-flight op
  logic        kill_q, kill_d;          // in-flight op was flushed
  logic [3:0]  wdog_q, wdog_d;          // busy cycles without a result
  logic        last_grant_q, last_grant_d;
  logic        err_q, err_d;

  // Registered writeback ports
  logic        wb0_valid_q, wb0_valid_d;
  logic [4:0]  wb0_rd_q, wb0_rd_d;
  logic [31:0] wb0_value_q, wb0_value_d;
  logic        wb1_valid_q, wb1_valid_d;
  logic [4:0]  wb1_rd_q, wb1_rd_d;
  logic [31:0] wb1_value_q, wb1_value_d;

  // Combinational helpers
  logic        issue_window_s;  // state allows a new issue this cycle
  logic        any_req_s;
  logic        winner_s;        // requester chosen if a grant happens
  logic        grant_s;
  logic        wb_fire_s;       // result is delivered to the owner
  logic [3:0]  wdog_inc_s;
  logic        timeout_s;

  // Arbitration: decide whether a grant happens and who wins it.
  always_comb begin
    issue_window_s = 1'b0;
    any_req_s      = req0_valid_i | req1_valid_i;
    winner_s       = 1'b0;

    case (state_q)
      ST_IDLE: issue_window_s = 1'b1;
      // Busy only opens up in the cycle the current result comes back.
      ST_BUSY: issue_window_s = mul_wb_valid_i;
      default: issue_window_s = 1'b0;
    endcase

    if (req0_valid_i && req1_valid_i) begin
      winner_s = ~last_grant_q;
    end else if (req1_valid_i) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end

    // Reset gating keeps the combinational handshake at 0 during reset.
    grant_s = ~rst_i & ~flush_i & issue_window_s & any_req_s;
  end

  // Handshake and operand outputs to requesters and the multiplier.
  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    mul_valid_o  = 1'b0;
    mul_ra_o     = 32'd0;
    mul_rb_o     = 32'd0;

    if (grant_s) begin
      mul_valid_o = 1'b1;
      if (winner_s) begin
        req1_ready_o = 1'b1;
        mul_ra_o     = req1_ra_i;
        mul_rb_o     = req1_rb_i;
      end else begin
        req0_ready_o = 1'b1;
        mul_ra_o     = req0_ra_i;
        mul_rb_o     = req0_rb_i;
      end
    end else begin
      mul_valid_o = 1'b0;
    end
  end

  // Result delivery and watchdog expiry conditions.
  always_comb begin
    wdog_inc_s = wdog_q + 4'd1;
    // A result arriving together with a flush is dropped just like a result
    // whose operation was flushed earlier.
    wb_fire_s  = (state_q == ST_BUSY) & mul_wb_valid_i & ~kill_q & ~flush_i;
    timeout_s  = (state_q == ST_BUSY) & ~mul_wb_valid_i & (wdog_inc_s == WDOG_LIMIT_C);
  end

  // FSM next state plus owner, kill, watchdog and error bookkeeping.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rd_d         = rd_q;
    kill_d       = kill_q;
    wdog_d       = wdog_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        // A stray result while idle has no owner and is ignored.
        kill_d = 1'b0;
        if (grant_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mul_wb_valid_i) begin
          // The outstanding result has returned, so any kill has served
          // its purpose.
          kill_d = 1'b0;
          if (grant_s) begin
            state_d = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (timeout_s) begin
          // Give up on the operation: no writeback will be produced.
          err_d   = 1'b1;
          state_d = ST_IDLE;
          kill_d  = 1'b0;
          wdog_d  = wdog_inc_s;
        end else begin
          wdog_d = wdog_inc_s;
          if (flush_i) begin
            kill_d = 1'b1;
          end else begin
            kill_d = kill_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        kill_d  = 1'b0;
      end
    endcase

    if (grant_s) begin
      owner_d      = winner_s;
      rd_d         = winner_s ? req1_rd_i : req0_rd_i;
      wdog_d       = 4'd0;
      last_grant_d = winner_s;
    end else begin
      owner_d      = owner_q;
      rd_d         = rd_q;
      last_grant_d = last_grant_q;
    end
  end

  // Writeback port next values: strobe the owner, hold data otherwise.
  always_comb begin
    wb0_valid_d = 1'b0;
    wb0_rd_d    = wb0_rd_q;
    wb0_value_d = wb0_value_q;
    wb1_valid_d = 1'b0;
    wb1_rd_d    = wb1_rd_q;
    wb1_value_d = wb1_value_q;

    if (wb_fire_s) begin
      if (owner_q) begin
        wb1_valid_d = 1'b1;
        wb1_rd_d    = rd_q;
        wb1_value_d = mul_wb_value_i;
      end else begin
        wb0_valid_d = 1'b1;
        wb0_rd_d    = rd_q;
        wb0_value_d = mul_wb_value_i;
      end
    end else begin
      wb0_valid_d = 1'b0;
      wb1_valid_d = 1'b0;
    end
  end

  // State and output registers; reset abandons any in-flight multiply.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      rd_q         <= 5'd0;
      kill_q       <= 1'b0;
      wdog_q       <= 4'd0;
      last_grant_q <= 1'b1;   // so requester 0 wins the first tie
      err_q        <= 1'b0;
      wb0_valid_q  <= 1'b0;
      wb0_rd_q     <= 5'd0;
      wb0_value_q  <= 32'd0;
      wb1_valid_q  <= 1'b0;
      wb1_rd_q     <= 5'd0;
      wb1_value_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rd_q         <= rd_d;
      kill_q       <= kill_d;
      wdog_q       <= wdog_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      wb0_valid_q  <= wb0_valid_d;
      wb0_rd_q     <= wb0_rd_d;
      wb0_value_q  <= wb0_value_d;
      wb1_valid_q  <= wb1_valid_d;
      wb1_rd_q     <= wb1_rd_d;
      wb1_value_q  <= wb1_value_d;
    end
  end

  assign wb0_valid_o = wb0_valid_q;
  assign wb0_rd_o    = wb0_rd_q;
  assign wb0_value_o = wb0_value_q;
  assign wb1_valid_o = wb1_valid_q;
  assign wb1_rd_o    = wb1_rd_q;
  assign wb1_value_o = wb1_value_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_biriscv_mul_arbiter.sv
// Self-checking bench for biriscv_mul_arbiter: a table of directed cycles,
// hand-written corner sequences, and randomized traffic against a
// transaction-level reference model.
module tb_biriscv_mul_arbiter;

  localparam int WDOG = 15;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req0_ready_o;
  logic [31:0] req0_ra_i, req0_rb_i;
  logic [4:0]  req0_rd_i;
  logic        req1_valid_i, req1_ready_o;
  logic [31:0] req1_ra_i, req1_rb_i;
  logic [4:0]  req1_rd_i;
  logic        mul_valid_o;
  logic [31:0] mul_ra_o, mul_rb_o;
  logic        mul_wb_valid_i;
  logic [31:0] mul_wb_value_i;
  logic        flush_i;
  logic        wb0_valid_o, wb1_valid_o;
  logic [4:0]  wb0_rd_o, wb1_rd_o;
  logic [31:0] wb0_value_o, wb1_value_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  biriscv_mul_arbiter #(.WDOG_LIMIT(WDOG)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_ra_i(req0_ra_i), .req0_rb_i(req0_rb_i), .req0_rd_i(req0_rd_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_ra_i(req1_ra_i), .req1_rb_i(req1_rb_i), .req1_rd_i(req1_rd_i),
    .mul_valid_o(mul_valid_o), .mul_ra_o(mul_ra_o), .mul_rb_o(mul_rb_o),
    .mul_wb_valid_i(mul_wb_valid_i), .mul_wb_value_i(mul_wb_value_i),
    .flush_i(flush_i),
    .wb0_valid_o(wb0_valid_o), .wb0_rd_o(wb0_rd_o), .wb0_value_o(wb0_value_o),
    .wb1_valid_o(wb1_valid_o), .wb1_rd_o(wb1_rd_o), .wb1_value_o(wb1_value_o),
    .err_o(err_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_busy, m_discard, m_err;
  int          m_owner, m_wait, m_tie;
  logic [4:0]  m_rd;
  bit          m_wbv [2];
  logic [4:0]  m_wbrd [2];
  logic [31:0] m_wbval [2];

  task automatic model_reset();
    m_busy = 0; m_discard = 0; m_err = 0;
    m_owner = 0; m_wait = 0; m_tie = 0; m_rd = 5'd0;
    for (int i = 0; i < 2; i++) begin
      m_wbv[i] = 0; m_wbrd[i] = 5'd0; m_wbval[i] = 32'd0;
    end
  endtask

  function automatic int m_winner();
    if (req0_valid_i && req1_valid_i) return m_tie;
    if (req0_valid_i) return 0;
    if (req1_valid_i) return 1;
    return -1;
  endfunction

  function automatic bit m_grant();
    return !rst_i && !flush_i && (!m_busy || mul_wb_valid_i) && (m_winner() >= 0);
  endfunction

  task automatic model_check(input string tag);
    int w = m_winner();
    bit g = m_grant();
    chk({tag, ".ready0"}, req0_ready_o, 32'(g && w == 0));
    chk({tag, ".ready1"}, req1_ready_o, 32'(g && w == 1));
    chk({tag, ".mul_valid"}, mul_valid_o, 32'(g));
    chk({tag, ".mul_ra"}, mul_ra_o, !g ? 32'd0 : (w == 0 ? req0_ra_i : req1_ra_i));
    chk({tag, ".mul_rb"}, mul_rb_o, !g ? 32'd0 : (w == 0 ? req0_rb_i : req1_rb_i));
    chk({tag, ".wb0_valid"}, wb0_valid_o, 32'(m_wbv[0]));
    chk({tag, ".wb0_rd"}, wb0_rd_o, 32'(m_wbrd[0]));
    chk({tag, ".wb0_value"}, wb0_value_o, m_wbval[0]);
    chk({tag, ".wb1_valid"}, wb1_valid_o, 32'(m_wbv[1]));
    chk({tag, ".wb1_rd"}, wb1_rd_o, 32'(m_wbrd[1]));
    chk({tag, ".wb1_value"}, wb1_value_o, m_wbval[1]);
    chk({tag, ".err"}, err_o, 32'(m_err));
  endtask

  // Advance the model by one clock edge using the inputs of that cycle.
  task automatic model_step();
    int w = m_winner();
    bit g = m_grant();
    m_wbv[0] = 0;
    m_wbv[1] = 0;
    if (m_busy) begin
      if (mul_wb_valid_i) begin
        if (!m_discard && !flush_i) begin
          m_wbv[m_owner]   = 1;
          m_wbrd[m_owner]  = m_rd;
          m_wbval[m_owner] = mul_wb_value_i;
        end
        m_busy = 0; m_discard = 0;
      end else begin
        m_wait++;
        if (flush_i) m_discard = 1;
        if (m_wait >= WDOG) begin
          m_err = 1; m_busy = 0; m_discard = 0;
        end
      end
    end
    if (g) begin
      m_busy = 1; m_owner = w; m_wait = 0; m_tie = 1 - w;
      m_rd = (w == 0) ? req0_rd_i : req1_rd_i;
    end
  endtask

  // ---------------- cycle helpers ----------------
  task automatic to_neg(input string tag);
    @(negedge clk_i);
    model_check(tag);
  endtask

  task automatic to_pos();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic clear_in();
    req0_valid_i = 0; req1_valid_i = 0;
    mul_wb_valid_i = 0; mul_wb_value_i = 32'd0; flush_i = 0;
  endtask

  // Assert reset now, check every output is 0 at once, release two edges later.
  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    model_reset();
    chk("rst.ready0", req0_ready_o, 32'd0);
    chk("rst.ready1", req1_ready_o, 32'd0);
    chk("rst.mul_valid", mul_valid_o, 32'd0);
    chk("rst.mul_ra", mul_ra_o, 32'd0);
    chk("rst.wb0_valid", wb0_valid_o, 32'd0);
    chk("rst.wb0_rd", wb0_rd_o, 32'd0);
    chk("rst.wb0_value", wb0_value_o, 32'd0);
    chk("rst.wb1_valid", wb1_valid_o, 32'd0);
    chk("rst.wb1_rd", wb1_rd_o, 32'd0);
    chk("rst.wb1_value", wb1_value_o, 32'd0);
    chk("rst.err", err_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        v0, v1, wb, fl;
    logic [31:0] wbval;
    logic        e_rdy0, e_rdy1, e_wb0v, e_wb1v;
    logic [31:0] e_mra;
    logic [4:0]  e_rd0, e_rd1;
    logic [31:0] e_val0, e_val1;
  } vec_t;

  function automatic vec_t mk(logic v0, logic v1, logic wb, logic fl, logic [31:0] wbval,
                              logic r0, logic r1, logic w0, logic w1, logic [31:0] mra,
                              logic [4:0] rd0, logic [4:0] rd1, logic [31:0] val0, logic [31:0] val1);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.wb = wb; v.fl = fl; v.wbval = wbval;
    v.e_rdy0 = r0; v.e_rdy1 = r1; v.e_wb0v = w0; v.e_wb1v = w1; v.e_mra = mra;
    v.e_rd0 = rd0; v.e_rd1 = rd1; v.e_val0 = val0; v.e_val1 = val1;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    // Contention after reset (grants 0,1,0,1, back-to-back), then flush in idle.
    tbl[0]  = mk(1,1,0,0,  0, 1,0,0,0,  3, 0,0,  0,  0);
    tbl[1]  = mk(1,1,0,0,  0, 0,0,0,0,  0, 0,0,  0,  0);
    tbl[2]  = mk(1,1,1,0, 21, 0,1,0,0, 11, 0,0,  0,  0);
    tbl[3]  = mk(1,1,0,0,  0, 0,0,1,0,  0, 5,0, 21,  0);
    tbl[4]  = mk(1,1,1,0,143, 1,0,0,0,  3, 5,0, 21,  0);
    tbl[5]  = mk(1,1,0,0,  0, 0,0,0,1,  0, 5,9, 21,143);
    tbl[6]  = mk(1,1,1,0, 21, 0,1,0,0, 11, 5,9, 21,143);
    tbl[7]  = mk(0,0,0,0,  0, 0,0,1,0,  0, 5,9, 21,143);
    tbl[8]  = mk(0,0,1,0,143, 0,0,0,0,  0, 5,9, 21,143);
    tbl[9]  = mk(0,0,0,0,  0, 0,0,0,1,  0, 5,9, 21,143);
    tbl[10] = mk(1,0,0,1,  0, 0,0,0,0,  0, 5,9, 21,143);
    tbl[11] = mk(1,0,0,0,  0, 1,0,0,0,  3, 5,9, 21,143);
    tbl[12] = mk(0,0,1,0, 77, 0,0,0,0,  0, 5,9, 21,143);
    tbl[13] = mk(0,0,0,0,  0, 0,0,1,0,  0, 5,9, 77,143);

    clear_in();
    req0_ra_i = 32'd3;  req0_rb_i = 32'd7;  req0_rd_i = 5'd5;
    req1_ra_i = 32'd11; req1_rb_i = 32'd13; req1_rd_i = 5'd9;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      req0_valid_i = tbl[i].v0; req1_valid_i = tbl[i].v1;
      mul_wb_valid_i = tbl[i].wb; flush_i = tbl[i].fl; mul_wb_value_i = tbl[i].wbval;
      to_neg("tbl");
      chk($sformatf("tbl%0d.ready0", i), req0_ready_o, 32'(tbl[i].e_rdy0));
      chk($sformatf("tbl%0d.ready1", i), req1_ready_o, 32'(tbl[i].e_rdy1));
      chk($sformatf("tbl%0d.mul_valid", i), mul_valid_o, 32'(tbl[i].e_rdy0 | tbl[i].e_rdy1));
      chk($sformatf("tbl%0d.mul_ra", i), mul_ra_o, tbl[i].e_mra);
      chk($sformatf("tbl%0d.wb0_valid", i), wb0_valid_o, 32'(tbl[i].e_wb0v));
      chk($sformatf("tbl%0d.wb1_valid", i), wb1_valid_o, 32'(tbl[i].e_wb1v));
      chk($sformatf("tbl%0d.wb0_rd", i), wb0_rd_o, 32'(tbl[i].e_rd0));
      chk($sformatf("tbl%0d.wb1_rd", i), wb1_rd_o, 32'(tbl[i].e_rd1));
      chk($sformatf("tbl%0d.wb0_value", i), wb0_value_o, tbl[i].e_val0);
      chk($sformatf("tbl%0d.wb1_value", i), wb1_value_o, tbl[i].e_val1);
      to_pos();
    end

    // ---- single request, result after 5 cycles ----
    clear_in(); do_reset();
    req0_valid_i = 1; req0_ra_i = 32'd3; req0_rb_i = 32'd7; req0_rd_i = 5'd5;
    to_neg("single");
    chk("single.ready0", req0_ready_o, 32'd1);
    chk("single.mul_valid", mul_valid_o, 32'd1);
    chk("single.mul_ra", mul_ra_o, 32'd3);
    chk("single.mul_rb", mul_rb_o, 32'd7);
    to_pos();
    req0_valid_i = 0;
    for (int k = 1; k < 5; k++) begin
      to_neg("single.wait"); chk("single.wait_wb0", wb0_valid_o, 32'd0); to_pos();
    end
    mul_wb_valid_i = 1; mul_wb_value_i = 32'd21;
    to_neg("single.ret"); to_pos();
    mul_wb_valid_i = 0;
    to_neg("single.wb");
    chk("single.wb0_valid", wb0_valid_o, 32'd1);
    chk("single.wb0_rd", wb0_rd_o, 32'd5);
    chk("single.wb0_value", wb0_value_o, 32'd21);
    chk("single.wb1_valid", wb1_valid_o, 32'd0);
    to_pos();
    to_neg("single.after");
    chk("single.wb0_pulse", wb0_valid_o, 32'd0);
    chk("single.wb0_hold", wb0_value_o, 32'd21);
    to_pos();

    // ---- flush while busy ----
    clear_in(); do_reset();
    req1_valid_i = 1; req1_ra_i = 32'd5; req1_rb_i = 32'd6; req1_rd_i = 5'd9;
    to_neg("flush"); chk("flush.ready1", req1_ready_o, 32'd1); to_pos();
    req1_valid_i = 0;
    to_neg("flush.c1"); to_pos();
    flush_i = 1; to_neg("flush.c2"); to_pos(); flush_i = 0;
    to_neg("flush.c3"); to_pos();
    mul_wb_valid_i = 1; mul_wb_value_i = 32'h1234; to_neg("flush.c4"); to_pos();
    mul_wb_valid_i = 0;
    req0_valid_i = 1; req0_ra_i = 32'd2; req0_rb_i = 32'd4; req0_rd_i = 5'd12;
    to_neg("flush.c5");
    chk("flush.no_wb1", wb1_valid_o, 32'd0);
    chk("flush.next_ready0", req0_ready_o, 32'd1);
    to_pos();
    req0_valid_i = 0;
    to_neg("flush.c6"); to_pos();
    to_neg("flush.c7"); to_pos();
    mul_wb_valid_i = 1; mul_wb_value_i = 32'd8; to_neg("flush.c8"); to_pos();
    mul_wb_valid_i = 0;
    to_neg("flush.c9");
    chk("flush.wb0_valid", wb0_valid_o, 32'd1);
    chk("flush.wb0_rd", wb0_rd_o, 32'd12);
    chk("flush.wb0_value", wb0_value_o, 32'd8);
    to_pos();

    // ---- flush coinciding with writeback ----
    clear_in(); do_reset();
    req0_valid_i = 1; req0_ra_i = 32'd1; req0_rb_i = 32'd1; req0_rd_i = 5'd3;
    to_neg("fwb.c0"); chk("fwb.ready0_c0", req0_ready_o, 32'd1); to_pos();
    to_neg("fwb.c1"); chk("fwb.busy_ready0", req0_ready_o, 32'd0); to_pos();
    mul_wb_valid_i = 1; flush_i = 1; mul_wb_value_i = 32'd99;
    to_neg("fwb.c2");
    chk("fwb.blocked_ready0", req0_ready_o, 32'd0);
    chk("fwb.blocked_mul_valid", mul_valid_o, 32'd0);
    to_pos();
    mul_wb_valid_i = 0; flush_i = 0;
    to_neg("fwb.c3");
    chk("fwb.no_wb0", wb0_valid_o, 32'd0);
    chk("fwb.late_ready0", req0_ready_o, 32'd1);
    to_pos();
    req0_valid_i = 0;
    mul_wb_valid_i = 1; mul_wb_value_i = 32'd5; to_neg("fwb.c4"); to_pos();
    mul_wb_valid_i = 0;
    to_neg("fwb.c5"); chk("fwb.wb0_valid", wb0_valid_o, 32'd1); chk("fwb.wb0_value", wb0_value_o, 32'd5); to_pos();

    // ---- watchdog ----
    clear_in(); do_reset();
    req0_valid_i = 1; req0_rd_i = 5'd7;
    to_neg("wd.c0"); chk("wd.ready0", req0_ready_o, 32'd1); to_pos();
    req0_valid_i = 0;
    for (int k = 1; k <= WDOG; k++) begin
      to_neg("wd.busy"); chk($sformatf("wd.err_c%0d", k), err_o, 32'd0); to_pos();
    end
    req1_valid_i = 1; req1_rd_i = 5'd10;
    to_neg("wd.c16");
    chk("wd.err_set", err_o, 32'd1);
    chk("wd.idle_ready1", req1_ready_o, 32'd1);
    chk("wd.no_wb0", wb0_valid_o, 32'd0);
    to_pos();
    req1_valid_i = 0;
    mul_wb_valid_i = 1; mul_wb_value_i = 32'habc; to_neg("wd.c17"); to_pos();
    mul_wb_valid_i = 0;
    to_neg("wd.c18");
    chk("wd.wb1_valid", wb1_valid_o, 32'd1);
    chk("wd.wb1_rd", wb1_rd_o, 32'd10);
    chk("wd.err_sticky", err_o, 32'd1);
    to_pos();

    // ---- reset mid-operation ----
    clear_in(); do_reset();
    req0_valid_i = 1; req0_rd_i = 5'd4;
    to_neg("rmid.c0"); chk("rmid.ready0", req0_ready_o, 32'd1); to_pos();
    req0_valid_i = 0;
    to_neg("rmid.c1"); to_pos();
    req0_valid_i = 1; req1_valid_i = 1; mul_wb_valid_i = 1; mul_wb_value_i = 32'd42;
    do_reset();
    req0_valid_i = 0; req1_valid_i = 0;
    to_neg("rmid.stray"); to_pos();
    mul_wb_valid_i = 0;
    req0_valid_i = 1; req1_valid_i = 1;
    to_neg("rmid.post");
    chk("rmid.no_wb0", wb0_valid_o, 32'd0);
    chk("rmid.no_wb1", wb1_valid_o, 32'd0);
    chk("rmid.first_ready0", req0_ready_o, 32'd1);
    chk("rmid.first_ready1", req1_ready_o, 32'd0);
    to_pos();

    // ---- randomized traffic against the model ----
    clear_in(); do_reset();
    for (int c = 0; c < 600; c++) begin
      req0_valid_i   = ($urandom_range(0, 1) == 1);
      req1_valid_i   = ($urandom_range(0, 1) == 1);
      mul_wb_valid_i = ($urandom_range(0, 3) == 0);
      flush_i        = ($urandom_range(0, 15) == 0);
      req0_ra_i = $urandom; req0_rb_i = $urandom; req0_rd_i = 5'($urandom_range(0, 31));
      req1_ra_i = $urandom; req1_rb_i = $urandom; req1_rd_i = 5'($urandom_range(0, 31));
      mul_wb_value_i = $urandom;
      to_neg("rnd");
      to_pos();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
